multicycle_ctrl: RTL and testbench
==================================

# multicycle_ctrl

Multi-cycle main controller for the MIPS datapath: a Moore-style FSM that sequences one instruction over 3–5 cycles through a single shared memory port and a single ALU. It replaces the single-cycle combinational control unit and ALU-source/PC muxing. It drives every datapath strobe and mux select, and keeps a retired-instruction counter.

## Interface
- No parameters; all encodings come from the shared package.
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- opcode  in  6  instruction[31:26] from the instruction register
- alu_zero  in  1  ALU zero flag (branch compare)
- mem_ready  in  1  memory access completes this cycle
- pc_write, pc_write_cond  out  1  unconditional PC load / PC load if alu_zero
- pc_source  out  2  00 ALU result, 01 ALUOut (branch target), 10 jump address
- i_or_d  out  1  memory address: 0 PC, 1 ALUOut
- mem_read, mem_write, ir_write  out  1  memory and IR strobes
- reg_write  out  1  register file write enable
- reg_dst  out  2  00 rt, 01 rd, 10 r31
- mem_to_reg  out  2  00 ALUOut, 01 MDR, 10 PC
- alu_src_a  out  1  0 PC, 1 rs data
- alu_src_b  out  2  00 rt data, 01 constant 4, 10 sign-ext imm, 11 sign-ext imm<<2
- alu_op  out  2  00 add, 01 sub, 10 funct-decoded, 11 reserved (never driven)
- illegal_op  out  1  one-cycle pulse on an unsupported opcode
- state  out  4  current FSM state (debug)
- instr_retired  out  32  count of completed instructions

## Operation
- Supported opcodes: R-type 000000, lw 100011, sw 101011, beq 000100, j 000010, jal 000011, addi 001000.
- Encodings for `state`: FETCH 0, DECODE 1, MEM_ADDR 2, MEM_READ 3, MEM_WB 4, MEM_WRITE 5, R_EXEC 6, R_WB 7, BRANCH 8, JUMP 9, JAL 10, ADDI_EXEC 11, ADDI_WB 12. Codes 13–15 are unreachable and transition to FETCH.
- Outputs per state; unlisted outputs are 0:
  - FETCH: mem_read, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00. ir_write and pc_write are asserted only in a cycle where the access completes.
  - DECODE: alu_src_a=0, alu_src_b=11, alu_op=00 (branch target into ALUOut).
  - MEM_ADDR and ADDI_EXEC: alu_src_a=1, alu_src_b=10, alu_op=00.
  - MEM_READ: mem_read, i_or_d=1.
  - MEM_WRITE: mem_write, i_or_d=1.
  - MEM_WB: reg_write, reg_dst=00, mem_to_reg=01.
  - R_EXEC: alu_src_a=1, alu_src_b=00, alu_op=10.
  - R_WB: reg_write, reg_dst=01, mem_to_reg=00.
  - ADDI_WB: reg_write, reg_dst=00, mem_to_reg=00.
  - BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond, pc_source=01.
  - JUMP: pc_write, pc_source=10.
  - JAL: pc_write, pc_source=10, reg_write, reg_dst=10, mem_to_reg=10. PC already holds PC+4 from FETCH.
- Transitions:
  - FETCH→DECODE.
  - DECODE dispatches on opcode: lw/sw→MEM_ADDR, R→R_EXEC, beq→BRANCH, j→JUMP, jal→JAL, addi→ADDI_EXEC.
  - MEM_ADDR→MEM_READ for lw, MEM_WRITE for sw; MEM_READ→MEM_WB.
  - R_EXEC→R_WB; ADDI_EXEC→ADDI_WB.
  - MEM_WB, MEM_WRITE, R_WB, ADDI_WB, BRANCH, JUMP, JAL→FETCH.
- Illegal opcode: DECODE→FETCH, illegal_op=1 in that DECODE cycle, instr_retired unchanged.
- instr_retired increments by 1 on every transition from a final state into FETCH. It wraps 0xFFFF_FFFF→0 silently.

## Timing
- Cycles per instruction with zero wait states: lw 5; sw, R, addi 4; beq, j, jal 3; illegal 2.
- State and counter are registered; control outputs are decoded combinationally from state, and additionally from mem_ready in FETCH, MEM_READ and MEM_WRITE.
- Reset values: state=FETCH, instr_retired=0, illegal_op=0.
- While rst=1, all strobes (pc_write, pc_write_cond, mem_read, mem_write, ir_write, reg_write) are forced 0.
- First fetch begins on the first rising edge after rst deasserts.
- Reset asserted mid-instruction aborts it: no partial write strobe is emitted after assertion, and the instruction is not counted.

## Configuration
- MIPS_MEM_WAIT_EN defined: FETCH, MEM_READ and MEM_WRITE hold until mem_ready=1.
  - mem_read/mem_write stay asserted throughout the wait.
  - ir_write/pc_write pulse only in the mem_ready cycle.
  - A MEM_WRITE cycle with mem_ready=0 does not advance and does not retire.
- Undefined: mem_ready is ignored, every memory state lasts exactly one cycle, and ir_write/pc_write are asserted for the whole FETCH cycle.

## Structure
- Shared package mips_ctrl_pkg holds:
  - opcode constants
  - state encoding
  - alu_op, pc_source, reg_dst, mem_to_reg and alu_src_b encodings (shared with alu_control and the datapath muxes)
- One natural sub-module: multicycle_ctrl_outdec, the purely combinational state(+mem_ready)→control-word decoder. The parent holds the state register, next-state logic and counter.

## Test plan
- Reset, then lw (opcode 100011) with mem_ready tied 1 → states 0,1,2,3,4,0; reg_write=1 with mem_to_reg=01 only in state 4; instr_retired=1.
- beq with alu_zero=1, then with alu_zero=0 → 3 cycles each; pc_write_cond=1 and pc_source=01 in BRANCH; instr_retired advances by 2.
- jal → JAL state asserts pc_write, reg_write, reg_dst=10, mem_to_reg=10 together; next state FETCH.
- Opcode 111111 → illegal_op pulse in DECODE, back to FETCH after 2 cycles, counter unchanged, no reg_write or mem_write.
- MIPS_MEM_WAIT_EN, sw with mem_ready low for 3 cycles in MEM_WRITE → mem_write held 4 cycles, retire only after the ready cycle.
- rst asserted in R_EXEC → state=0 immediately (asynchronous), reg_write never pulses, counter unchanged. Preload counter to 0xFFFF_FFFF, retire one → 0.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS controller, alu_control and datapath muxes.
// Opcode constants, FSM state codes, mux-select encodings and the control word struct.
package mips_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_R_EXEC    = 4'd6,
        S_R_WB      = 4'd7,
        S_BRANCH    = 4'd8,
        S_JUMP      = 4'd9,
        S_JAL       = 4'd10,
        S_ADDI_EXEC = 4'd11,
        S_ADDI_WB   = 4'd12
    } state_t;

    typedef enum logic [1:0] {
        ALU_OP_ADD   = 2'b00,
        ALU_OP_SUB   = 2'b01,
        ALU_OP_FUNCT = 2'b10,
        ALU_OP_RSVD  = 2'b11
    } alu_op_t;

    typedef enum logic [1:0] {
        PC_SRC_ALU    = 2'b00,
        PC_SRC_ALUOUT = 2'b01,
        PC_SRC_JUMP   = 2'b10
    } pc_source_t;

    typedef enum logic [1:0] {
        REG_DST_RT = 2'b00,
        REG_DST_RD = 2'b01,
        REG_DST_RA = 2'b10
    } reg_dst_t;

    typedef enum logic [1:0] {
        M2R_ALUOUT = 2'b00,
        M2R_MDR    = 2'b01,
        M2R_PC     = 2'b10
    } mem_to_reg_t;

    typedef enum logic [1:0] {
        ALU_B_REG     = 2'b00,
        ALU_B_FOUR    = 2'b01,
        ALU_B_IMM     = 2'b10,
        ALU_B_IMM_SH2 = 2'b11
    } alu_src_b_t;

    typedef struct packed {
        logic        pc_write;
        logic        pc_write_cond;
        pc_source_t  pc_source;
        logic        i_or_d;
        logic        mem_read;
        logic        mem_write;
        logic        ir_write;
        logic        reg_write;
        reg_dst_t    reg_dst;
        mem_to_reg_t mem_to_reg;
        logic        alu_src_a;
        alu_src_b_t  alu_src_b;
        alu_op_t     alu_op;
    } ctrl_word_t;

    // States that talk to the shared memory port and may stretch on wait states.
    function automatic logic is_mem_state(input state_t s);
        return (s == S_FETCH) || (s == S_MEM_READ) || (s == S_MEM_WRITE);
    endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Controller <-> datapath bundle: instruction/status inputs, control strobes and debug outputs.
// The controller uses the master modport, the datapath the slave modport.
interface multicycle_ctrl_if;

    logic [5:0]  opcode;
    logic        alu_zero;
    logic        mem_ready;

    logic        pc_write;
    logic        pc_write_cond;
    logic [1:0]  pc_source;
    logic        i_or_d;
    logic        mem_read;
    logic        mem_write;
    logic        ir_write;
    logic        reg_write;
    logic [1:0]  reg_dst;
    logic [1:0]  mem_to_reg;
    logic        alu_src_a;
    logic [1:0]  alu_src_b;
    logic [1:0]  alu_op;
    logic        illegal_op;
    logic [3:0]  state;
    logic [31:0] instr_retired;

    modport master (
        input  opcode, alu_zero, mem_ready,
        output pc_write, pc_write_cond, pc_source, i_or_d,
               mem_read, mem_write, ir_write, reg_write,
               reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op,
               illegal_op, state, instr_retired
    );

    modport slave (
        output opcode, alu_zero, mem_ready,
        input  pc_write, pc_write_cond, pc_source, i_or_d,
               mem_read, mem_write, ir_write, reg_write,
               reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op,
               illegal_op, state, instr_retired
    );

endinterface

// File: rtl/multicycle_ctrl_outdec.sv
// Purely combinational state(+mem_ready) -> control word decoder for multicycle_ctrl.
// With MIPS_MEM_WAIT_EN defined, IR/PC load in FETCH only in the mem_ready cycle.
module multicycle_ctrl_outdec
    import mips_ctrl_pkg::*;
(
    input  state_t     state,
    input  logic       mem_ready,
    output ctrl_word_t ctrl
);

    logic fetch_done;

`ifdef MIPS_MEM_WAIT_EN
    assign fetch_done = mem_ready;
`else
    logic unused_mem_ready;
    assign unused_mem_ready = mem_ready;
    assign fetch_done       = 1'b1;
`endif

    always_comb begin
        ctrl = '0;
        case (state)
            S_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.i_or_d    = 1'b0;
                ctrl.alu_src_a = 1'b0;
                ctrl.alu_src_b = ALU_B_FOUR;
                ctrl.alu_op    = ALU_OP_ADD;
                ctrl.pc_source = PC_SRC_ALU;
                ctrl.ir_write  = fetch_done;
                ctrl.pc_write  = fetch_done;
            end
            // Speculatively compute the branch target into ALUOut.
            S_DECODE: begin
                ctrl.alu_src_a = 1'b0;
                ctrl.alu_src_b = ALU_B_IMM_SH2;
                ctrl.alu_op    = ALU_OP_ADD;
            end
            S_MEM_ADDR, S_ADDI_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = ALU_B_IMM;
                ctrl.alu_op    = ALU_OP_ADD;
            end
            S_MEM_READ: begin
                ctrl.mem_read = 1'b1;
                ctrl.i_or_d   = 1'b1;
            end
            S_MEM_WRITE: begin
                ctrl.mem_write = 1'b1;
                ctrl.i_or_d    = 1'b1;
            end
            S_MEM_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.reg_dst    = REG_DST_RT;
                ctrl.mem_to_reg = M2R_MDR;
            end
            S_R_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = ALU_B_REG;
                ctrl.alu_op    = ALU_OP_FUNCT;
            end
            S_R_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.reg_dst    = REG_DST_RD;
                ctrl.mem_to_reg = M2R_ALUOUT;
            end
            S_ADDI_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.reg_dst    = REG_DST_RT;
                ctrl.mem_to_reg = M2R_ALUOUT;
            end
            S_BRANCH: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_src_b     = ALU_B_REG;
                ctrl.alu_op        = ALU_OP_SUB;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_source     = PC_SRC_ALUOUT;
            end
            S_JUMP: begin
                ctrl.pc_write  = 1'b1;
                ctrl.pc_source = PC_SRC_JUMP;
            end
            // PC already holds PC+4 from FETCH, so it is the link value for r31.
            S_JAL: begin
                ctrl.pc_write   = 1'b1;
                ctrl.pc_source  = PC_SRC_JUMP;
                ctrl.reg_write  = 1'b1;
                ctrl.reg_dst    = REG_DST_RA;
                ctrl.mem_to_reg = M2R_PC;
            end
            default: begin
                ctrl = '0;
            end
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle MIPS main controller: state register, next-state logic, retired counter.
// Define MIPS_MEM_WAIT_EN to stretch FETCH/MEM_READ/MEM_WRITE until mem_ready.
module multicycle_ctrl
    import mips_ctrl_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    multicycle_ctrl_if.master    bus
);

    state_t     state_q;
    state_t     state_d;
    ctrl_word_t ctrl;
    logic [31:0] retired_count;
    logic       retire;
    logic       illegal;
    logic       mem_done;

`ifdef MIPS_MEM_WAIT_EN
    assign mem_done = bus.mem_ready;
`else
    assign mem_done = 1'b1;
`endif

    // alu_zero is consumed by the datapath together with pc_write_cond.
    logic unused_alu_zero;
    assign unused_alu_zero = bus.alu_zero;

    always_comb begin
        state_d = state_q;
        retire  = 1'b0;
        illegal = 1'b0;
        case (state_q)
            S_FETCH:     state_d = S_DECODE;
            S_DECODE: begin
                case (bus.opcode)
                    OP_LW, OP_SW: state_d = S_MEM_ADDR;
                    OP_RTYPE:     state_d = S_R_EXEC;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_J:         state_d = S_JUMP;
                    OP_JAL:       state_d = S_JAL;
                    OP_ADDI:      state_d = S_ADDI_EXEC;
                    default: begin
                        state_d = S_FETCH;
                        illegal = 1'b1;
                    end
                endcase
            end
            S_MEM_ADDR:  state_d = (bus.opcode == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
            S_MEM_READ:  state_d = S_MEM_WB;
            S_R_EXEC:    state_d = S_R_WB;
            S_ADDI_EXEC: state_d = S_ADDI_WB;
            S_MEM_WRITE, S_MEM_WB, S_R_WB, S_ADDI_WB,
            S_BRANCH, S_JUMP, S_JAL: begin
                state_d = S_FETCH;
                retire  = 1'b1;
            end
            default:     state_d = S_FETCH;
        endcase
        // A memory state that has not completed holds and does not retire.
        if (is_mem_state(state_q) && !mem_done) begin
            state_d = state_q;
            retire  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            retired_count <= 32'd0;
        end else if (retire) begin
            retired_count <= retired_count + 32'd1;
        end
    end

    multicycle_ctrl_outdec u_outdec (
        .state     (state_q),
        .mem_ready (bus.mem_ready),
        .ctrl      (ctrl)
    );

    // Strobes are gated by rst so an aborted instruction never leaks a write.
    assign bus.pc_write      = ctrl.pc_write      & ~rst;
    assign bus.pc_write_cond = ctrl.pc_write_cond & ~rst;
    assign bus.mem_read      = ctrl.mem_read      & ~rst;
    assign bus.mem_write     = ctrl.mem_write     & ~rst;
    assign bus.ir_write      = ctrl.ir_write      & ~rst;
    assign bus.reg_write     = ctrl.reg_write     & ~rst;
    assign bus.illegal_op    = illegal            & ~rst;

    assign bus.pc_source     = ctrl.pc_source;
    assign bus.i_or_d        = ctrl.i_or_d;
    assign bus.reg_dst       = ctrl.reg_dst;
    assign bus.mem_to_reg    = ctrl.mem_to_reg;
    assign bus.alu_src_a     = ctrl.alu_src_a;
    assign bus.alu_src_b     = ctrl.alu_src_b;
    assign bus.alu_op        = ctrl.alu_op;
    assign bus.state         = state_q;
    assign bus.instr_retired = retired_count;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: directed and random instructions vs a phase-list model.
// Honours MIPS_MEM_WAIT_EN when the build defines it.
module tb_multicycle_ctrl;

    logic clk;
    logic rst;
    int   checks_total;
    int   checks_passed;
    logic [31:0] model_count;

`ifdef MIPS_MEM_WAIT_EN
    localparam bit WAIT_EN = 1'b1;
`else
    localparam bit WAIT_EN = 1'b0;
`endif

    multicycle_ctrl_if bus ();

    multicycle_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic bit is_legal(input logic [5:0] op);
        return op == 6'b000000 || op == 6'b100011 || op == 6'b101011 ||
               op == 6'b000100 || op == 6'b000010 || op == 6'b000011 ||
               op == 6'b001000;
    endfunction

    // Control word expected for a given phase, straight from the per-state output table.
    function automatic logic [18:0] exp_ctrl(input int st, input logic ready, input logic [5:0] op);
        logic pcw, pcwc, iord, mr, mw, irw, rw, asa, ill;
        logic [1:0] pcs, rd, m2r, asb, aop;
        {pcw, pcwc, iord, mr, mw, irw, rw, asa, ill} = '0;
        {pcs, rd, m2r, asb, aop} = '0;
        case (st)
            0: begin
                mr = 1'b1; asb = 2'b01;
                irw = WAIT_EN ? ready : 1'b1;
                pcw = WAIT_EN ? ready : 1'b1;
            end
            1: begin asb = 2'b11; ill = !is_legal(op); end
            2, 11: begin asa = 1'b1; asb = 2'b10; end
            3: begin mr = 1'b1; iord = 1'b1; end
            4: begin rw = 1'b1; m2r = 2'b01; end
            5: begin mw = 1'b1; iord = 1'b1; end
            6: begin asa = 1'b1; aop = 2'b10; end
            7: begin rw = 1'b1; rd = 2'b01; end
            8: begin asa = 1'b1; aop = 2'b01; pcwc = 1'b1; pcs = 2'b01; end
            9: begin pcw = 1'b1; pcs = 2'b10; end
            10: begin pcw = 1'b1; pcs = 2'b10; rw = 1'b1; rd = 2'b10; m2r = 2'b10; end
            12: begin rw = 1'b1; end
            default: ;
        endcase
        return {pcw, pcwc, pcs, iord, mr, mw, irw, rw, rd, m2r, asa, asb, aop, ill};
    endfunction

    function automatic logic [18:0] obs_ctrl();
        return {bus.pc_write, bus.pc_write_cond, bus.pc_source, bus.i_or_d,
                bus.mem_read, bus.mem_write, bus.ir_write, bus.reg_write,
                bus.reg_dst, bus.mem_to_reg, bus.alu_src_a, bus.alu_src_b,
                bus.alu_op, bus.illegal_op};
    endfunction

    function automatic logic [5:0] obs_strobes();
        return {bus.pc_write, bus.pc_write_cond, bus.mem_read,
                bus.mem_write, bus.ir_write, bus.reg_write};
    endfunction

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        checks_total++;
        assert (observed === expected) checks_passed++;
        else $error("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
    endtask

    // Drives one instruction through the controller and checks every cycle.
    // wait_mode: 0 memory always ready, 1 random waits, 2 three wait cycles per memory phase.
    // abort_phase >= 0 asserts rst in that phase instead of completing the instruction.
    task automatic apply_stimulus(input logic [5:0] op, input logic zero,
                                  input int wait_mode, input int abort_phase);
        int   seq[$];
        int   waits;
        bit   stay;
        bit   mem_phase;
        logic ready;
        case (op)
            6'b100011: seq = '{0, 1, 2, 3, 4};
            6'b101011: seq = '{0, 1, 2, 5};
            6'b000000: seq = '{0, 1, 6, 7};
            6'b001000: seq = '{0, 1, 11, 12};
            6'b000100: seq = '{0, 1, 8};
            6'b000010: seq = '{0, 1, 9};
            6'b000011: seq = '{0, 1, 10};
            default:   seq = '{0, 1};
        endcase
        for (int p = 0; p < seq.size(); p++) begin
            waits = 0;
            mem_phase = (seq[p] == 0) || (seq[p] == 3) || (seq[p] == 5);
            do begin
                case (wait_mode)
                    0:       ready = 1'b1;
                    1:       ready = (waits >= 3) ? 1'b1 : logic'($urandom_range(0, 2) != 0);
                    default: ready = (waits >= 3) ? 1'b1 : 1'b0;
                endcase
                bus.opcode    = op;
                bus.alu_zero  = zero;
                bus.mem_ready = ready;
                #1;
                check_output("state", 32'(bus.state), 32'(seq[p]));
                check_output($sformatf("ctrl_s%0d", seq[p]), 32'(obs_ctrl()),
                             32'(exp_ctrl(seq[p], ready, op)));
                check_output("retired", bus.instr_retired, model_count);
                if (p == abort_phase) begin
                    #1 rst = 1'b1;
                    #1;
                    model_count = 32'd0;
                    check_output("abort_state", 32'(bus.state), 32'd0);
                    check_output("abort_strobes", 32'(obs_strobes()), 32'd0);
                    check_output("abort_retired", bus.instr_retired, model_count);
                    @(negedge clk);
                    check_output("abort_hold_strobes", 32'(obs_strobes()), 32'd0);
                    check_output("abort_hold_state", 32'(bus.state), 32'd0);
                    rst = 1'b0;
                    return;
                end
                @(negedge clk);
                stay = WAIT_EN && mem_phase && !ready;
                waits++;
            end while (stay);
        end
        if (is_legal(op)) model_count = model_count + 32'd1;
    endtask

    initial begin
        logic [5:0] op;
        logic [5:0] legal_ops [7];
        checks_total  = 0;
        checks_passed = 0;
        model_count   = 32'd0;
        legal_ops = '{6'b000000, 6'b100011, 6'b101011, 6'b000100,
                      6'b000010, 6'b000011, 6'b001000};

        rst           = 1'b1;
        bus.opcode    = 6'b100011;
        bus.alu_zero  = 1'b0;
        bus.mem_ready = 1'b1;
        repeat (2) begin
            @(negedge clk);
            check_output("reset_state", 32'(bus.state), 32'd0);
            check_output("reset_retired", bus.instr_retired, 32'd0);
            check_output("reset_illegal", 32'(bus.illegal_op), 32'd0);
            check_output("reset_strobes", 32'(obs_strobes()), 32'd0);
        end
        rst = 1'b0;

        // R-type aborted by reset in R_EXEC, then the directed instruction mix.
        apply_stimulus(6'b000000, 1'b0, 0, 2);
        apply_stimulus(6'b100011, 1'b0, 0, -1);
        check_output("lw_retired", bus.instr_retired, 32'd1);
        apply_stimulus(6'b000100, 1'b1, 0, -1);
        apply_stimulus(6'b000100, 1'b0, 0, -1);
        check_output("beq_retired", bus.instr_retired, 32'd3);
        apply_stimulus(6'b000011, 1'b0, 0, -1);
        apply_stimulus(6'b111111, 1'b0, 0, -1);
        check_output("illegal_retired", bus.instr_retired, 32'd4);
        apply_stimulus(6'b101011, 1'b0, 2, -1);
        apply_stimulus(6'b000000, 1'b0, 0, -1);
        apply_stimulus(6'b001000, 1'b0, 0, -1);
        apply_stimulus(6'b000010, 1'b0, 0, -1);

        for (int i = 0; i < 50; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                do op = 6'($urandom_range(0, 63)); while (is_legal(op));
            end else begin
                op = legal_ops[$urandom_range(0, 6)];
            end
            apply_stimulus(op, logic'($urandom_range(0, 1)), 1, -1);
        end

        // Counter wrap: preload all-ones mid-FETCH, retire one instruction.
        force dut.retired_count = 32'hFFFF_FFFF;
        #1;
        release dut.retired_count;
        model_count = 32'hFFFF_FFFF;
        check_output("preload_retired", bus.instr_retired, 32'hFFFF_FFFF);
        apply_stimulus(6'b000010, 1'b0, 0, -1);
        check_output("wrap_retired", bus.instr_retired, 32'd0);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
